// File: rtl/vend_pkg.sv
// Shared vending definitions: payout FSM encoding, coin values and the
// saturating counter helper used by the change dispenser.
package vend_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VEND   = 3'd1,
    SELECT = 3'd2,
    PAY    = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_e;

  localparam int unsigned COIN_NICKEL  = 5;
  localparam int unsigned COIN_DIME    = 10;
  localparam int unsigned COIN_QUARTER = 25;
  localparam int unsigned PRICE        = 25;

  function automatic logic [3:0] sat_inc4(input logic [3:0] val);
    logic [3:0] res;
    if (val == 4'hF) begin
      res = val;
    end else begin
      res = val + 4'h1;
    end
    return res;
  endfunction

endpackage

// File: rtl/hopper_watchdog.sv
// Hopper ack watchdog: counts consecutive PAY cycles and flags expiry on the
// TIMEOUT-th edge spent waiting. Only instantiated when CHG_TIMEOUT_EN is set.
module hopper_watchdog
  import vend_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_pay,
  output logic expire
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Counter restarts from zero whenever PAY is left, so each coin gets a fresh budget.
  always_comb begin
    cnt_d = '0;
    if (in_pay) begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = '0;
    end
  end

  // Wait-cycle counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = in_pay && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/change_dispenser.sv
// Vend payout sequencer: releases the item, pays change as dimes then nickels
// over the hopper handshake, then strobes credit_clr. CHG_TIMEOUT_EN adds a hopper watchdog.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int unsigned BITS = 6
`ifdef CHG_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 255
`endif
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            vend_req,
  input  logic [BITS-1:0] change_in,
  input  logic            coin_ack,
  input  logic            err_clr,
  output logic            item_pulse,
  output logic            coin_valid,
  output logic            coin_sel,
  output logic            credit_clr,
  output logic            busy,
  output logic            err,
  output logic [3:0]      dimes_paid,
  output logic [3:0]      nickels_paid
);

  state_e          state_q, state_d;
  logic [BITS-1:0] rem_q, rem_d;
  logic            coin_sel_q, coin_sel_d;
  logic [3:0]      dimes_q, dimes_d;
  logic [3:0]      nickels_q, nickels_d;
  logic            item_pulse_q, item_pulse_d;
  logic            coin_valid_q, coin_valid_d;
  logic            credit_clr_q, credit_clr_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;
  logic [BITS-1:0] coin_val_s;
  logic            wd_expire_s;

`ifdef CHG_TIMEOUT_EN
  hopper_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .in_pay  (state_q == PAY),
    .expire  (wd_expire_s)
  );
`else
  assign wd_expire_s = 1'b0;
`endif

  assign coin_val_s = coin_sel_q ? BITS'(COIN_DIME) : BITS'(COIN_NICKEL);

  // Next-state, datapath and next-output decode; outputs follow state_d so they are flop-driven.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    coin_sel_d = coin_sel_q;
    dimes_d    = dimes_q;
    nickels_d  = nickels_q;
    case (state_q)
      IDLE: begin
        if (vend_req) begin
          state_d   = VEND;
          rem_d     = change_in;
          dimes_d   = 4'd0;
          nickels_d = 4'd0;
        end else begin
          state_d = IDLE;
        end
      end
      VEND: state_d = SELECT;
      SELECT: begin
        if (rem_q == '0) begin
          state_d = DONE;
        end else if (rem_q >= BITS'(COIN_DIME)) begin
          state_d    = PAY;
          coin_sel_d = 1'b1;
        end else if (rem_q >= BITS'(COIN_NICKEL)) begin
          state_d    = PAY;
          coin_sel_d = 1'b0;
        end else begin
          state_d = ERR;
        end
      end
      PAY: begin
        // A transfer on the same edge as watchdog expiry takes priority.
        if (coin_ack) begin
          state_d = SELECT;
          rem_d   = rem_q - coin_val_s;
          if (coin_sel_q) begin
            dimes_d = sat_inc4(dimes_q);
          end else begin
            nickels_d = sat_inc4(nickels_q);
          end
        end else if (wd_expire_s) begin
          state_d = ERR;
        end else begin
          state_d = PAY;
        end
      end
      DONE: state_d = IDLE;
      ERR: begin
        if (err_clr) begin
          state_d = IDLE;
          rem_d   = '0;
        end else begin
          state_d = ERR;
        end
      end
      default: begin
        state_d = IDLE;
        rem_d   = '0;
      end
    endcase
    item_pulse_d = (state_d == VEND);
    coin_valid_d = (state_d == PAY);
    credit_clr_d = (state_d == DONE);
    busy_d       = (state_d == VEND) || (state_d == SELECT) ||
                   (state_d == PAY)  || (state_d == DONE);
    err_d        = (state_d == ERR);
  end

  // State, datapath and output registers; async reset abandons any payout in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      rem_q        <= '0;
      coin_sel_q   <= 1'b0;
      dimes_q      <= 4'd0;
      nickels_q    <= 4'd0;
      item_pulse_q <= 1'b0;
      coin_valid_q <= 1'b0;
      credit_clr_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      coin_sel_q   <= coin_sel_d;
      dimes_q      <= dimes_d;
      nickels_q    <= nickels_d;
      item_pulse_q <= item_pulse_d;
      coin_valid_q <= coin_valid_d;
      credit_clr_q <= credit_clr_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign item_pulse   = item_pulse_q;
  assign coin_valid   = coin_valid_q;
  assign coin_sel     = coin_sel_q;
  assign credit_clr   = credit_clr_q;
  assign busy         = busy_q;
  assign err          = err_q;
  assign dimes_paid   = dimes_q;
  assign nickels_paid = nickels_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: the driver queues expected payout events,
// a monitor pops and compares them as the DUT strobes; a hopper model acks coins.
module tb_change_dispenser;

  localparam logic [1:0] K_ITEM = 2'd0;
  localparam logic [1:0] K_COIN = 2'd1;
  localparam logic [1:0] K_DONE = 2'd2;
  localparam logic [1:0] K_ERR  = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic       sel;
    logic [3:0] dimes;
    logic [3:0] nick;
  } exp_t;

  logic       clk, reset_n, vend_req, coin_ack, err_clr;
  logic [5:0] change_in;
  logic       item_pulse, coin_valid, coin_sel, credit_clr, busy, err;
  logic [3:0] dimes_paid, nickels_paid;

  int   n_tests = 0, n_fail = 0;
  int   n_done = 0, n_err = 0, exp_done = 0, exp_err = 0;
  int   n_valid_cyc = 0, cyc = 0, item_cyc = 0, done_cyc = 0, vend_cyc = 0;
  bit   hop_en = 1'b1;
  int   ack_delay = 2;
  exp_t sb_q[$];

  change_dispenser #(
    .BITS (6)
`ifdef CHG_TIMEOUT_EN
    , .TIMEOUT (8)
`endif
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .vend_req     (vend_req),
    .change_in    (change_in),
    .coin_ack     (coin_ack),
    .err_clr      (err_clr),
    .item_pulse   (item_pulse),
    .coin_valid   (coin_valid),
    .coin_sel     (coin_sel),
    .credit_clr   (credit_clr),
    .busy         (busy),
    .err          (err),
    .dimes_paid   (dimes_paid),
    .nickels_paid (nickels_paid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t mk(input logic [1:0] k, input logic s, input logic [3:0] d, input logic [3:0] n);
    exp_t e;
    e.kind = k; e.sel = s; e.dimes = d; e.nick = n;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic push(input exp_t e);
    sb_q.push_back(e);
    if (e.kind == K_DONE) exp_done++;
    if (e.kind == K_ERR)  exp_err++;
  endtask

  task automatic sb_cmp(input string name, input exp_t act);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: unexpected output 0x%0h, nothing expected", name, act);
    end else begin
      e = sb_q.pop_front();
      check(name, 32'(act), 32'(e));
    end
  endtask

  // Hopper model: acks after ack_delay cycles of coin_valid.
  initial begin
    int hcnt;
    hcnt = 0;
    coin_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (coin_valid && hop_en) begin
        hcnt++;
        coin_ack = (hcnt >= ack_delay);
      end else begin
        hcnt = 0;
        coin_ack = 1'b0;
      end
    end
  end

  // Monitor: samples on the falling edge and checks against the scoreboard.
  initial begin
    bit prev_xfer, prev_valid, prev_sel, prev_err;
    prev_xfer = 0; prev_valid = 0; prev_sel = 0; prev_err = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset_n) begin
        if (prev_xfer) check("coin_gap", 32'(coin_valid), 32'd0);
        if (coin_valid && prev_valid) check("sel_stable", 32'(coin_sel), 32'(prev_sel));
        if (coin_valid) begin
          n_valid_cyc++;
          check("busy_in_pay", 32'(busy), 32'd1);
        end
        if (item_pulse) begin
          item_cyc = cyc;
          sb_cmp("sb_item", mk(K_ITEM, 1'b0, 4'd0, 4'd0));
        end
        if (coin_valid && coin_ack) sb_cmp("sb_coin", mk(K_COIN, coin_sel, 4'd0, 4'd0));
        if (credit_clr) begin
          done_cyc = cyc;
          n_done++;
          sb_cmp("sb_done", mk(K_DONE, 1'b0, dimes_paid, nickels_paid));
        end
        if (err && !prev_err) begin
          n_err++;
          sb_cmp("sb_err", mk(K_ERR, 1'b0, dimes_paid, nickels_paid));
        end
      end
      prev_xfer  = coin_valid & coin_ack;
      prev_valid = coin_valid;
      prev_sel   = coin_sel;
      prev_err   = err;
    end
  end

  task automatic vend(input logic [5:0] c);
    vend_req  = 1'b1;
    change_in = c;
    @(posedge clk);
    vend_cyc = cyc;
    #1;
    vend_req  = 1'b0;
    change_in = 6'd0;
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (!coin_valid && k < 50) begin
      @(posedge clk); #1; k++;
    end
    if (!coin_valid) begin
      n_tests++; n_fail++;
      $display("FAIL %s: coin_valid never rose within 50 cycles", name);
    end
  endtask

  task automatic wait_ev(input string name);
    int k;
    k = 0;
    while ((n_done < exp_done || n_err < exp_err) && k < 300) begin
      @(posedge clk); #1; k++;
    end
    if (n_done < exp_done || n_err < exp_err) begin
      n_tests++; n_fail++;
      $display("FAIL %s: timeout, done=%0d err=%0d, expected done=%0d err=%0d",
               name, n_done, n_err, exp_done, exp_err);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({item_pulse, coin_valid, coin_sel, credit_clr, busy, err, dimes_paid, nickels_paid});
  endfunction

  initial begin
    int v0;
    reset_n = 1'b0; vend_req = 1'b0; change_in = 6'd0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", outs(), 32'd0);
    @(posedge clk); #3 reset_n = 1'b1;
    @(posedge clk); #1;
    check("idle_after_reset", outs(), 32'd0);

    // 1: reset asserted mid-PAY
    hop_en = 1'b0;
    push(mk(K_ITEM, 1'b0, 4'd0, 4'd0));
    vend(6'd20);
    wait_valid("rst_mid_pay");
    #2 reset_n = 1'b0;
    #1 check("rst_async_valid", 32'(coin_valid), 32'd0);
    check("rst_async_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    check("rst_release_outputs", outs(), 32'd0);
    hop_en = 1'b1;

    // 2: change 20 -> two dimes
    push(mk(K_ITEM, 1'b0, 4'd0, 4'd0));
    push(mk(K_COIN, 1'b1, 4'd0, 4'd0));
    push(mk(K_COIN, 1'b1, 4'd0, 4'd0));
    push(mk(K_DONE, 1'b0, 4'd2, 4'd0));
    vend(6'd20);
    wait_ev("vend20");
    check("vend20_item_latency", 32'(item_cyc - vend_cyc), 32'd1);
    check("vend20_counts_hold", 32'({dimes_paid, nickels_paid}), 32'h20);

    // 3: change 15 -> dime then nickel
    push(mk(K_ITEM, 1'b0, 4'd0, 4'd0));
    push(mk(K_COIN, 1'b1, 4'd0, 4'd0));
    push(mk(K_COIN, 1'b0, 4'd0, 4'd0));
    push(mk(K_DONE, 1'b0, 4'd1, 4'd1));
    vend(6'd15);
    wait_ev("vend15");

    // 5: change 7 -> nickel then ERR; vend_req during payout ignored
    push(mk(K_ITEM, 1'b0, 4'd0, 4'd0));
    push(mk(K_COIN, 1'b0, 4'd0, 4'd0));
    push(mk(K_ERR, 1'b0, 4'd0, 4'd1));
    vend(6'd7);
    wait_valid("vend7");
    vend_req = 1'b1; change_in = 6'd20;
    @(posedge clk); #1;
    vend_req = 1'b0; change_in = 6'd0;
    wait_ev("vend7");
    check("err_state", 32'({err, busy}), 32'b10);
    repeat (3) @(posedge clk);
    #1 check("err_sticky", 32'(err), 32'd1);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check("err_cleared", 32'({err, busy}), 32'b00);
    check("err_counts_hold", 32'({dimes_paid, nickels_paid}), 32'h01);

    // 4: change 0 -> no coins, credit_clr two cycles after item
    v0 = n_valid_cyc;
    push(mk(K_ITEM, 1'b0, 4'd0, 4'd0));
    push(mk(K_DONE, 1'b0, 4'd0, 4'd0));
    vend(6'd0);
    wait_ev("vend0");
    check("vend0_item_latency", 32'(item_cyc - vend_cyc), 32'd1);
    check("vend0_clr_delay", 32'(done_cyc - item_cyc), 32'd2);
    check("vend0_no_coin", 32'(n_valid_cyc - v0), 32'd0);

`ifdef CHG_TIMEOUT_EN
    // 6: watchdog expiry after 8 PAY cycles, then ack on the 8th edge wins
    hop_en = 1'b0;
    v0 = n_valid_cyc;
    push(mk(K_ITEM, 1'b0, 4'd0, 4'd0));
    push(mk(K_ERR, 1'b0, 4'd0, 4'd0));
    vend(6'd5);
    wait_ev("wd_expire");
    check("wd_pay_cycles", 32'(n_valid_cyc - v0), 32'd8);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    hop_en = 1'b1;
    ack_delay = 8;
    push(mk(K_ITEM, 1'b0, 4'd0, 4'd0));
    push(mk(K_COIN, 1'b0, 4'd0, 4'd0));
    push(mk(K_DONE, 1'b0, 4'd0, 4'd1));
    vend(6'd5);
    wait_ev("wd_ack_wins");
    check("wd_ack_no_err", 32'(err), 32'd0);
`endif

    repeat (3) @(posedge clk);
    #1 check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
